rvfi_commit_checker: RTL

- Parametrised successor to the single-lane monitor bundle, for the out-of-order core's retire stage.
- Observes up to NRET retire lanes per cycle and checks commit-stream integrity: order continuity, PC chaining, x0 writes, lane packing, halt discipline and forward progress.
- Keeps a retired-instruction count and a sticky first-error record for the testbench.
- Sits beside the monitor interface in the verification top and drives the bench's error/halt/summary signals.

---
 rtl/rvfi_commit_checker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rvfi_commit_checker.sv
// Commit-stream integrity checker for a multi-lane retire interface.
// Flags order, PC chain, x0, lane-packing, halt and watchdog violations; records the first error.
module rvfi_commit_checker #(
    parameter int unsigned NRET    = 2,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRET-1:0]        mon_valid,
    input  logic [64*NRET-1:0]     mon_order,
    input  logic [NRET-1:0]        mon_halt,
    input  logic [5*NRET-1:0]      mon_rd_addr,
    input  logic [32*NRET-1:0]     mon_rd_wdata,
    input  logic [32*NRET-1:0]     mon_pc_rdata,
    input  logic [32*NRET-1:0]     mon_pc_wdata,
    output logic                   halted,
    output logic                   error,
    output logic [2:0]             error_code,
    output logic [$clog2(NRET):0]  error_lane,
    output logic [63:0]            error_order,
    output logic [CNT_W-1:0]       retired_count
);

    localparam int unsigned LW   = $clog2(NRET) + 1;
    localparam int unsigned PW   = $clog2(NRET + 1);
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    localparam logic [2:0] C_ORDER   = 3'd1;
    localparam logic [2:0] C_PC      = 3'd2;
    localparam logic [2:0] C_X0      = 3'd3;
    localparam logic [2:0] C_GAP     = 3'd4;
    localparam logic [2:0] C_TIMEOUT = 3'd5;
    localparam logic [2:0] C_HALT    = 3'd6;

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERROR} state_t;

    state_t             state_q, state_d;
    logic [63:0]        exp_order_q, exp_order_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic               last_pc_vld_q, last_pc_vld_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               halted_d, error_d;
    logic [2:0]         code_d;
    logic [LW-1:0]      lane_d;
    logic [63:0]        eorder_d;
    logic [CNT_W-1:0]   count_d;

    logic               ord_f, pc_f, x0_f, gap_f, to_f, halt_f, seen_halt;
    logic [LW-1:0]      ord_l, pc_l, x0_l, gap_l, halt_l, fail_lane;
    logic [2:0]         fail_code;
    logic [PW-1:0]      pop;
    logic [31:0]        hi_pcw;

    // Checks, priority resolution and next-state
    always_comb begin
        state_d       = state_q;
        exp_order_d   = exp_order_q;
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
        wd_d          = wd_q;
        halted_d      = halted;
        error_d       = error;
        code_d        = error_code;
        lane_d        = error_lane;
        eorder_d      = error_order;
        count_d       = retired_count;
        ord_f = 1'b0; pc_f = 1'b0; x0_f = 1'b0; gap_f = 1'b0; halt_f = 1'b0;
        ord_l = '0;   pc_l = '0;   x0_l = '0;   gap_l = '0;   halt_l = '0;
        seen_halt = 1'b0;
        pop       = '0;
        hi_pcw    = last_pc_q;
        fail_code = 3'd0;
        fail_lane = '0;

        if (mon_valid[0] && last_pc_vld_q && mon_pc_rdata[31:0] != last_pc_q) begin
            pc_f = 1'b1;
        end

        for (int k = 0; k < int'(NRET); k++) begin
            if (mon_valid[k]) begin
                if (!ord_f && mon_order[64*k +: 64] != exp_order_q + 64'(k)) begin
                    ord_f = 1'b1;
                    ord_l = LW'(k);
                end
                if (!x0_f && mon_rd_addr[5*k +: 5] == 5'd0 && mon_rd_wdata[32*k +: 32] != 32'd0) begin
                    x0_f = 1'b1;
                    x0_l = LW'(k);
                end
                if (!halt_f && (seen_halt || state_q == ST_HALTED)) begin
                    halt_f = 1'b1;
                    halt_l = LW'(k);
                end
                if (mon_halt[k]) seen_halt = 1'b1;
                hi_pcw = mon_pc_wdata[32*k +: 32];
                pop    = pop + PW'(1);
            end
        end

        // Lanes above 0 are checked against their lower neighbour
        for (int k = 1; k < int'(NRET); k++) begin
            if (!gap_f && mon_valid[k] && !mon_valid[k-1]) begin
                gap_f = 1'b1;
                gap_l = LW'(k);
            end
            if (!pc_f && mon_valid[k] && mon_valid[k-1] &&
                mon_pc_rdata[32*k +: 32] != mon_pc_wdata[32*(k-1) +: 32]) begin
                pc_f = 1'b1;
                pc_l = LW'(k);
            end
        end

        to_f = (TIMEOUT != 0) && (state_q == ST_RUN) && (wd_q == WD_MAX);

        if (ord_f)       begin fail_code = C_ORDER;   fail_lane = ord_l;  end
        else if (pc_f)   begin fail_code = C_PC;      fail_lane = pc_l;   end
        else if (x0_f)   begin fail_code = C_X0;      fail_lane = x0_l;   end
        else if (gap_f)  begin fail_code = C_GAP;     fail_lane = gap_l;  end
        else if (to_f)   begin fail_code = C_TIMEOUT; fail_lane = '0;     end
        else if (halt_f) begin fail_code = C_HALT;    fail_lane = halt_l; end

        exp_order_d = exp_order_q + 64'(pop);
        count_d     = retired_count + CNT_W'(pop);
        if (|mon_valid) begin
            last_pc_d     = hi_pcw;
            last_pc_vld_d = 1'b1;
            wd_d          = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end

        case (state_q)
            ST_RUN, ST_HALTED: begin
                if (fail_code != 3'd0) begin
                    state_d  = ST_ERROR;
                    error_d  = 1'b1;
                    code_d   = fail_code;
                    lane_d   = fail_lane;
                    eorder_d = exp_order_q;
                end else if (state_q == ST_RUN && seen_halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            exp_order_q   <= '0;
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
            wd_q          <= '0;
            halted        <= 1'b0;
            error         <= 1'b0;
            error_code    <= '0;
            error_lane    <= '0;
            error_order   <= '0;
            retired_count <= '0;
        end else begin
            state_q       <= state_d;
            exp_order_q   <= exp_order_d;
            last_pc_q     <= last_pc_d;
            last_pc_vld_q <= last_pc_vld_d;
            wd_q          <= wd_d;
            halted        <= halted_d;
            error         <= error_d;
            error_code    <= code_d;
            error_lane    <= lane_d;
            error_order   <= eorder_d;
            retired_count <= count_d;
        end
    end

endmodule
